ws2812_in: RTL and testbench
============================

WS2812_IN -- requirements
Module: ws2812_in

Interface
REQ-001 Parameter CNT_SPLIT, default 8'd105 (0.525 us at 200 MHz), high-width threshold; high width below it decodes as bit 0, otherwise bit 1.
REQ-002 Parameter CNT_MIN, default 8'd30 (0.15 us), minimum legal high width.
REQ-003 Parameter CNT_MAX, default 8'd200 (1.00 us), maximum legal high width.
REQ-004 Parameter CNT_RST, default 14'd10000 (50 us), low time that ends a frame.
REQ-005 clk_in  input  1  system clock, 200 MHz; one clock; all logic on its rising edge.
REQ-006 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-007 ws2812_data_in  input  1  WS2812 serial line, asynchronous to clk_in.
REQ-008 pixel_data_out  output  24  last complete pixel, GRB order, first received bit in bit 23.
REQ-009 pixel_vld_out  output  1  one-cycle strobe; pixel_data_out valid.
REQ-010 frame_done_out  output  1  one-cycle strobe; end-of-frame latch detected.
REQ-011 bit_err_out  output  1  one-cycle strobe; pulse-width or truncation error.

Function
REQ-012 ws2812_data_in SHALL pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signal (sync and edge detection: 3 cycles of latency).
REQ-013 FSM states: IDLE, HIGH, LOW; a 14-bit width counter SHALL saturate at all-ones, never wrap.
REQ-014 IDLE: on synchronized rising edge -> HIGH, counter cleared to 0; otherwise remain.
REQ-015 HIGH: counter increments each cycle; on falling edge, the bit SHALL be decoded (count < CNT_SPLIT -> 0, else 1), shifted into a 24-bit register MSB-first, bit index incremented, then -> LOW with counter cleared.
REQ-016 On the falling edge that completes the 24th bit, pixel_data_out SHALL update and pixel_vld_out SHALL pulse high on the next cycle; bit index returns to 0.
REQ-017 LOW: counter increments; rising edge before CNT_RST -> HIGH with counter cleared; counter reaching CNT_RST -> IDLE.
REQ-018 On the LOW->IDLE transition, frame_done_out SHALL pulse one cycle if at least one bit was received since the previous frame_done_out.
REQ-019 A partial pixel (bit index != 0) at frame end SHALL be discarded, bit index cleared, and no pixel_vld_out issued.
REQ-020 Reaching IDLE from reset SHALL NOT produce frame_done_out.
REQ-021 pixel_vld_out and frame_done_out SHALL never assert in the same cycle; pixel_vld_out precedes frame_done_out whenever both apply.
REQ-022 A line held high SHALL keep the FSM in HIGH with the counter saturated and no decode until the falling edge.

Reset
REQ-023 On rst_n_in low: state IDLE, counters 0, shift register 0, synchronizer flops 0; pixel_data_out 24'h000000; pixel_vld_out, frame_done_out and bit_err_out 0.
REQ-024 Reset mid-frame SHALL discard all partial data; no strobes SHALL fire during or immediately after reset release.

Configuration
REQ-025 Macro WS2812_IN_ERR_CHK_EN: when defined, bit_err_out SHALL pulse one cycle for high width < CNT_MIN or > CNT_MAX (the bit still decodes per REQ-015) and for a partial pixel at frame end (REQ-019).
REQ-026 When WS2812_IN_ERR_CHK_EN is undefined, bit_err_out SHALL be tied to 0 and no checking logic SHALL be synthesized.

Structure
REQ-027 Package ws2812_pkg SHALL hold the default count constants, CNT_RST width, and the FSM state enum, shared with ws2812_out.
REQ-028 Sub-module ws2812_sync SHALL implement the 2-flop synchronizer and the rise/fall edge strobes.

Verification
REQ-029 24 bits of 0xA5C3F0 (bit 1 = 140 high / 110 low cycles, bit 0 = 70 / 180), then 10000 low -> pixel_data_out = 24'hA5C3F0, one pixel_vld_out, then one frame_done_out.
REQ-030 Three back-to-back pixels 0xFFFFFF, 0x000000, 0x123456 -> three pixel_vld_out strobes in order, single frame_done_out.
REQ-031 High widths 104 and 105 -> decoded 0 and 1 respectively (CNT_SPLIT boundary).
REQ-032 12 bits then 10000 low -> no pixel_vld_out, one frame_done_out; bit_err_out pulses only with WS2812_IN_ERR_CHK_EN.
REQ-033 High width 20 and 220 cycles with WS2812_IN_ERR_CHK_EN -> bit_err_out pulse on each; without the macro -> bit_err_out constantly 0.
REQ-034 Assert rst_n_in after 10 bits, release, then send full pixel 0x00FF00 -> pixel_data_out = 24'h00FF00, no residual bits, no strobe at reset release.

Source files
------------

// File: rtl/ws2812_pkg.sv
// -----------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 line receiver (ws2812_in) and transmitter
// (ws2812_out):
//   - default high/low timing thresholds in 200 MHz clock cycles
//   - width counter size, pixel size
//   - line-timing FSM state encoding
//   - saturating increment helper for the width counter
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package ws2812_pkg;

    localparam int unsigned CNT_W = 14;
    localparam int unsigned PIX_W = 24;
    localparam int unsigned IDX_W = 5;

    localparam logic [7:0]       DEF_CNT_SPLIT = 8'd105;    // 0.525 us
    localparam logic [7:0]       DEF_CNT_MIN   = 8'd30;     // 0.15 us
    localparam logic [7:0]       DEF_CNT_MAX   = 8'd200;    // 1.00 us
    localparam logic [CNT_W-1:0] DEF_CNT_RST   = 14'd10000; // 50 us

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } ws_state_e;

    // Width counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : (v + {{(CNT_W-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/ws2812_in_if.sv
// -----------------------------------------------------------------------------
// ws2812_in_if
// Decoded-pixel output bundle of ws2812_in.
//   pixel_data_out [23:0] : last complete pixel, GRB, first received bit in [23]
//   pixel_vld_out         : one-cycle strobe, pixel_data_out just updated
//   frame_done_out        : one-cycle strobe, end-of-frame latch detected
//   bit_err_out           : one-cycle strobe, pulse-width / truncation error
// master = receiver (drives), slave = consumer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface ws2812_in_if;
    import ws2812_pkg::*;

    logic [PIX_W-1:0] pixel_data_out;
    logic             pixel_vld_out;
    logic             frame_done_out;
    logic             bit_err_out;

    modport master (
        output pixel_data_out,
        output pixel_vld_out,
        output frame_done_out,
        output bit_err_out
    );

    modport slave (
        input pixel_data_out,
        input pixel_vld_out,
        input frame_done_out,
        input bit_err_out
    );

endinterface

// File: rtl/ws2812_sync.sv
// -----------------------------------------------------------------------------
// ws2812_sync
// Two-flop synchronizer for the asynchronous WS2812 line followed by
// registered rise/fall edge strobes. Line change to strobe: 3 clk_in cycles.
// The distance between a rise strobe and the next fall strobe equals the
// number of cycles the line was sampled high.
//   clk_in   : system clock
//   rst_n_in : asynchronous active-low reset
//   data_in  : raw serial line
//   rise_out : one-cycle strobe on synchronized 0->1
//   fall_out : one-cycle strobe on synchronized 1->0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module ws2812_sync (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic data_in,
    output logic rise_out,
    output logic fall_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Next-state of the synchronizer chain and edge strobes.
    always_comb begin
        meta_d = data_in;
        sync_d = meta_q;
        dly_d  = sync_q;
        rise_d = sync_q & ~dly_q;
        fall_d = ~sync_q & dly_q;
    end

    // Synchronizer and edge strobe registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_out = rise_q;
    assign fall_out = fall_q;

endmodule

// File: rtl/ws2812_in.sv
// -----------------------------------------------------------------------------
// ws2812_in
// WS2812 serial line receiver. Measures each high pulse, decodes it to a bit
// (short = 0, long = 1), assembles 24-bit GRB pixels MSB-first and detects the
// long low "latch" period that ends a frame.
//   Parameters: CNT_SPLIT (0/1 threshold), CNT_MIN / CNT_MAX (legal high
//               width), CNT_RST (low time ending a frame), all in clk cycles.
//   clk_in         : 200 MHz system clock
//   rst_n_in       : asynchronous active-low reset
//   ws2812_data_in : serial line, asynchronous to clk_in
//   pix_if         : master side of ws2812_in_if (pixel, strobes, error)
// Optional build macro WS2812_IN_ERR_CHK_EN adds high-width and truncated
// pixel checking on bit_err_out; without it bit_err_out is constant 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module ws2812_in
    import ws2812_pkg::*;
#(
    parameter logic [7:0]       CNT_SPLIT = DEF_CNT_SPLIT,
    parameter logic [7:0]       CNT_MIN   = DEF_CNT_MIN,
    parameter logic [7:0]       CNT_MAX   = DEF_CNT_MAX,
    parameter logic [CNT_W-1:0] CNT_RST   = DEF_CNT_RST
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         ws2812_data_in,
    ws2812_in_if.master  pix_if
);

    localparam logic [CNT_W-1:0] SPLIT_W  = {{(CNT_W-8){1'b0}}, CNT_SPLIT};
    localparam logic [IDX_W-1:0] LAST_IDX = 5'd23;

    logic rise_s;
    logic fall_s;

    ws2812_sync u_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .data_in  (ws2812_data_in),
        .rise_out (rise_s),
        .fall_out (fall_s)
    );

    ws_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [PIX_W-1:0] shift_q, shift_d;
    logic [PIX_W-1:0] pix_q,   pix_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             seen_q,  seen_d;   // a bit arrived since the last frame_done
    logic             vld_q,   vld_d;
    logic             done_q,  done_d;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             bit_s;
    logic [PIX_W-1:0] shifted_s;
`ifdef WS2812_IN_ERR_CHK_EN
    localparam logic [CNT_W-1:0] MIN_W = {{(CNT_W-8){1'b0}}, CNT_MIN};
    localparam logic [CNT_W-1:0] MAX_W = {{(CNT_W-8){1'b0}}, CNT_MAX};
    logic             err_q,   err_d;
`endif

    // Line-timing FSM: next state, width counter, bit assembly and strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        pix_d     = pix_q;
        idx_d     = idx_q;
        seen_d    = seen_q;
        vld_d     = 1'b0;
        done_d    = 1'b0;
`ifdef WS2812_IN_ERR_CHK_EN
        err_d     = 1'b0;
`endif
        // The counter is cleared on the rise cycle, so including the fall
        // cycle makes the value compared here equal the sampled high width.
        cnt_inc_s = sat_inc(cnt_q);
        bit_s     = (cnt_inc_s >= SPLIT_W);
        shifted_s = {shift_q[PIX_W-2:0], bit_s};

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_HIGH: begin
                if (fall_s) begin
                    state_d = ST_LOW;
                    cnt_d   = {CNT_W{1'b0}};
                    shift_d = shifted_s;
                    seen_d  = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        pix_d = shifted_s;
                        vld_d = 1'b1;
                        idx_d = {IDX_W{1'b0}};
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
`ifdef WS2812_IN_ERR_CHK_EN
                    err_d = (cnt_inc_s < MIN_W) || (cnt_inc_s > MAX_W);
`endif
                end else begin
                    // A line stuck high parks here with the counter saturated.
                    cnt_d = cnt_inc_s;
                end
            end

            ST_LOW: begin
                if (rise_s) begin
                    state_d = ST_HIGH;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_inc_s >= CNT_RST) begin
                    // Latch period: end of frame, drop any partial pixel.
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    done_d  = seen_q;
                    seen_d  = 1'b0;
                    idx_d   = {IDX_W{1'b0}};
                    shift_d = {PIX_W{1'b0}};
`ifdef WS2812_IN_ERR_CHK_EN
                    err_d   = (idx_q != {IDX_W{1'b0}});
`endif
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                idx_d   = {IDX_W{1'b0}};
                shift_d = {PIX_W{1'b0}};
            end
        endcase
    end

    // FSM state, counters, shift register and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            shift_q <= {PIX_W{1'b0}};
            pix_q   <= {PIX_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            seen_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            pix_q   <= pix_d;
            idx_q   <= idx_d;
            seen_q  <= seen_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

`ifdef WS2812_IN_ERR_CHK_EN
    // Error strobe register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign pix_if.bit_err_out = err_q;
`else
    // The width limits have no effect in this build; the expression folds to
    // a constant 0 so the parameter list stays identical across builds.
    assign pix_if.bit_err_out = 1'b0 & (CNT_MIN > CNT_MAX);
`endif

    assign pix_if.pixel_data_out = pix_q;
    assign pix_if.pixel_vld_out  = vld_q;
    assign pix_if.frame_done_out = done_q;

endmodule

// File: tb/tb_ws2812_in.sv
// -----------------------------------------------------------------------------
// tb_ws2812_in
// Directed self-checking bench for ws2812_in. The line is driven on falling
// clock edges; a negedge monitor counts strobes and records published pixels,
// and each test task compares those against hand-computed expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ws2812_in;

`ifdef WS2812_IN_ERR_CHK_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif
    localparam int GAP = 10000 + 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic line  = 1'b0;

    always #2.5 clk = ~clk;

    ws2812_in_if pix_if ();

    ws2812_in dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .ws2812_data_in (line),
        .pix_if         (pix_if)
    );

    int n_cmp = 0;
    int n_mis = 0;

    int          vld_cnt  = 0;
    int          fd_cnt   = 0;
    int          err_cnt  = 0;
    int          both_cnt = 0;
    longint      cyc      = 0;
    longint      vld_cyc  = 0;
    longint      fd_cyc   = 0;
    logic [23:0] pix_log[$];

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pix_if.pixel_vld_out === 1'b1) begin
            vld_cnt = vld_cnt + 1;
            vld_cyc = cyc;
            pix_log.push_back(pix_if.pixel_data_out);
        end
        if (pix_if.frame_done_out === 1'b1) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
        end
        if (pix_if.bit_err_out === 1'b1) err_cnt = err_cnt + 1;
        if (pix_if.pixel_vld_out === 1'b1 && pix_if.frame_done_out === 1'b1)
            both_cnt = both_cnt + 1;
    end

    task automatic send_bit(input int hi, input int lo);
        line = 1'b1;
        repeat (hi) @(negedge clk);
        line = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_pixel(input logic [23:0] v, input int hi1, input int lo1,
                              input int hi0, input int lo0);
        for (int i = 23; i >= 0; i--) begin
            if (v[i]) send_bit(hi1, lo1);
            else      send_bit(hi0, lo0);
        end
    endtask

    task automatic frame_gap();
        line = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        line  = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (pix_if.pixel_data_out !== 24'h000000) begin n_mis++; $display("FAIL reset_data: got %h want %h", pix_if.pixel_data_out, 24'h000000); end
        n_cmp++; if (pix_if.pixel_vld_out !== 1'b0) begin n_mis++; $display("FAIL reset_vld: got %b want 0", pix_if.pixel_vld_out); end
        n_cmp++; if (pix_if.frame_done_out !== 1'b0) begin n_mis++; $display("FAIL reset_fd: got %b want 0", pix_if.frame_done_out); end
        n_cmp++; if (pix_if.bit_err_out !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b want 0", pix_if.bit_err_out); end
        rst_n = 1'b1;
        repeat (GAP) @(negedge clk);
        n_cmp++; if (vld_cnt !== 0) begin n_mis++; $display("FAIL reset_no_vld: got %0d want 0", vld_cnt); end
        n_cmp++; if (fd_cnt !== 0) begin n_mis++; $display("FAIL reset_no_fd: got %0d want 0", fd_cnt); end
    endtask

    task automatic test_single_pixel();
        int v0 = vld_cnt; int f0 = fd_cnt; int e0 = err_cnt;
        send_pixel(24'hA5C3F0, 140, 110, 70, 180);
        frame_gap();
        n_cmp++; if (vld_cnt - v0 !== 1) begin n_mis++; $display("FAIL single_vld_cnt: got %0d want 1", vld_cnt - v0); end
        n_cmp++; if (pix_if.pixel_data_out !== 24'hA5C3F0) begin n_mis++; $display("FAIL single_data: got %h want %h", pix_if.pixel_data_out, 24'hA5C3F0); end
        n_cmp++; if (fd_cnt - f0 !== 1) begin n_mis++; $display("FAIL single_fd_cnt: got %0d want 1", fd_cnt - f0); end
        n_cmp++; if (!(fd_cyc > vld_cyc)) begin n_mis++; $display("FAIL single_order: fd cycle %0d vld cycle %0d", fd_cyc, vld_cyc); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_mis++; $display("FAIL single_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_back_to_back();
        int v0 = vld_cnt; int f0 = fd_cnt; int p0 = pix_log.size();
        logic [23:0] got;
        logic [23:0] exp_px[3];
        exp_px[0] = 24'hFFFFFF;
        exp_px[1] = 24'h000000;
        exp_px[2] = 24'h123456;
        for (int k = 0; k < 3; k++) send_pixel(exp_px[k], 140, 30, 70, 30);
        frame_gap();
        n_cmp++; if (vld_cnt - v0 !== 3) begin n_mis++; $display("FAIL b2b_vld_cnt: got %0d want 3", vld_cnt - v0); end
        for (int k = 0; k < 3; k++) begin
            got = (pix_log.size() > p0 + k) ? pix_log[p0 + k] : 24'hxxxxxx;
            n_cmp++; if (got !== exp_px[k]) begin n_mis++; $display("FAIL b2b_pixel%0d: got %h want %h", k, got, exp_px[k]); end
        end
        n_cmp++; if (fd_cnt - f0 !== 1) begin n_mis++; $display("FAIL b2b_fd_cnt: got %0d want 1", fd_cnt - f0); end
    endtask

    // Bit 23: 20 high (short, 0), 22: 220 high (long, 1), 21: 104 (0), 20: 105 (1).
    task automatic test_widths();
        int v0 = vld_cnt; int f0 = fd_cnt; int e0 = err_cnt;
        logic [19:0] low_bits = 20'h5A5C3;
        send_bit(20, 30);
        send_bit(220, 30);
        send_bit(104, 30);
        send_bit(105, 30);
        for (int i = 19; i >= 0; i--) begin
            if (low_bits[i]) send_bit(140, 30);
            else             send_bit(70, 30);
        end
        frame_gap();
        n_cmp++; if (vld_cnt - v0 !== 1) begin n_mis++; $display("FAIL width_vld_cnt: got %0d want 1", vld_cnt - v0); end
        n_cmp++; if (pix_if.pixel_data_out !== 24'h55A5C3) begin n_mis++; $display("FAIL width_data: got %h want %h", pix_if.pixel_data_out, 24'h55A5C3); end
        n_cmp++; if (err_cnt - e0 !== 2 * ERR_EN) begin n_mis++; $display("FAIL width_err_cnt: got %0d want %0d", err_cnt - e0, 2 * ERR_EN); end
        n_cmp++; if (fd_cnt - f0 !== 1) begin n_mis++; $display("FAIL width_fd_cnt: got %0d want 1", fd_cnt - f0); end
    endtask

    task automatic test_partial();
        int v0 = vld_cnt; int f0 = fd_cnt; int e0 = err_cnt;
        logic [11:0] bits = 12'hABC;
        for (int i = 11; i >= 0; i--) begin
            if (bits[i]) send_bit(140, 30);
            else         send_bit(70, 30);
        end
        frame_gap();
        n_cmp++; if (vld_cnt - v0 !== 0) begin n_mis++; $display("FAIL partial_vld_cnt: got %0d want 0", vld_cnt - v0); end
        n_cmp++; if (fd_cnt - f0 !== 1) begin n_mis++; $display("FAIL partial_fd_cnt: got %0d want 1", fd_cnt - f0); end
        n_cmp++; if (err_cnt - e0 !== ERR_EN) begin n_mis++; $display("FAIL partial_err_cnt: got %0d want %0d", err_cnt - e0, ERR_EN); end
        n_cmp++; if (pix_if.pixel_data_out !== 24'h55A5C3) begin n_mis++; $display("FAIL partial_data_kept: got %h want %h", pix_if.pixel_data_out, 24'h55A5C3); end
    endtask

    task automatic test_reset_mid();
        int v0 = vld_cnt; int f0 = fd_cnt; int e0 = err_cnt;
        logic [9:0] bits = 10'h2B7;
        for (int i = 9; i >= 0; i--) begin
            if (bits[i]) send_bit(140, 30);
            else         send_bit(70, 30);
        end
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (pix_if.pixel_data_out !== 24'h000000) begin n_mis++; $display("FAIL mid_reset_data: got %h want %h", pix_if.pixel_data_out, 24'h000000); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if ((vld_cnt - v0) + (fd_cnt - f0) + (err_cnt - e0) !== 0) begin n_mis++; $display("FAIL mid_reset_strobes: got %0d want 0", (vld_cnt - v0) + (fd_cnt - f0) + (err_cnt - e0)); end
        send_pixel(24'h00FF00, 140, 30, 70, 30);
        frame_gap();
        n_cmp++; if (vld_cnt - v0 !== 1) begin n_mis++; $display("FAIL mid_vld_cnt: got %0d want 1", vld_cnt - v0); end
        n_cmp++; if (pix_if.pixel_data_out !== 24'h00FF00) begin n_mis++; $display("FAIL mid_data: got %h want %h", pix_if.pixel_data_out, 24'h00FF00); end
        n_cmp++; if (fd_cnt - f0 !== 1) begin n_mis++; $display("FAIL mid_fd_cnt: got %0d want 1", fd_cnt - f0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_mis++; $display("FAIL mid_err_cnt: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_strobe_exclusive();
        n_cmp++; if (both_cnt !== 0) begin n_mis++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_widths();
        test_partial();
        test_reset_mid();
        test_strobe_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
